// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | mem_arbiter : round-robin two-port arbiter/sequencer for a single-port BRAM |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wr_data,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rd_data,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wr_data,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rd_data,
    output logic                  mem_rd_enable,
    output logic                  mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // RD_LATENCY is 1 or 2, so the counter never exceeds 1
    localparam logic [1:0] c_LAST_CNT = 2'(RD_LATENCY - 1);

    state_t                r_state, w_nxt_state;
    logic [1:0]            r_cnt, w_nxt_cnt;
    logic                  r_we, w_nxt_we;
    logic                  r_grant_id, w_nxt_grant_id;
    logic                  r_rd_en, w_nxt_rd_en;
    logic                  r_wr_en, w_nxt_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
    logic [DATA_WIDTH-1:0] r_wdata, w_nxt_wdata;
    logic                  r_p0_ack, w_nxt_p0_ack;
    logic                  r_p1_ack, w_nxt_p1_ack;
    logic [DATA_WIDTH-1:0] r_p0_rd, w_nxt_p0_rd;
    logic [DATA_WIDTH-1:0] r_p1_rd, w_nxt_p1_rd;
    logic                  r_busy, w_nxt_busy;

    logic                  w_win;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_grant_id <= 1'b1;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_p0_ack   <= 1'b0;
            r_p1_ack   <= 1'b0;
            r_p0_rd    <= '0;
            r_p1_rd    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_we       <= w_nxt_we;
            r_grant_id <= w_nxt_grant_id;
            r_rd_en    <= w_nxt_rd_en;
            r_wr_en    <= w_nxt_wr_en;
            r_addr     <= w_nxt_addr;
            r_wdata    <= w_nxt_wdata;
            r_p0_ack   <= w_nxt_p0_ack;
            r_p1_ack   <= w_nxt_p1_ack;
            r_p0_rd    <= w_nxt_p0_rd;
            r_p1_rd    <= w_nxt_p1_rd;
            r_busy     <= w_nxt_busy;
        end
    end

    // On a tie the port that did not win last time goes next
    always_comb begin
        w_win       = (p0_req && p1_req) ? ~r_grant_id : p1_req;
        w_sel_we    = w_win ? p1_we      : p0_we;
        w_sel_addr  = w_win ? p1_addr    : p0_addr;
        w_sel_wdata = w_win ? p1_wr_data : p0_wr_data;
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_we       = r_we;
        w_nxt_grant_id = r_grant_id;
        w_nxt_rd_en    = 1'b0;
        w_nxt_wr_en    = 1'b0;
        w_nxt_addr     = r_addr;
        w_nxt_wdata    = r_wdata;
        w_nxt_p0_ack   = 1'b0;
        w_nxt_p1_ack   = 1'b0;
        w_nxt_p0_rd    = r_p0_rd;
        w_nxt_p1_rd    = r_p1_rd;
        case (r_state)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    w_nxt_state    = S_ISSUE;
                    w_nxt_grant_id = w_win;
                    w_nxt_we       = w_sel_we;
                    w_nxt_addr     = w_sel_addr;
                    w_nxt_wdata    = w_sel_wdata;
                    w_nxt_wr_en    = w_sel_we;
                    w_nxt_rd_en    = ~w_sel_we;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_nxt_state  = S_DONE;
                    w_nxt_p0_ack = ~r_grant_id;
                    w_nxt_p1_ack = r_grant_id;
                end else begin
                    w_nxt_state = S_WAIT;
                    w_nxt_cnt   = '0;
                end
            end
            S_WAIT: begin
                if (r_cnt == c_LAST_CNT) begin
                    w_nxt_state  = S_DONE;
                    w_nxt_p0_ack = ~r_grant_id;
                    w_nxt_p1_ack = r_grant_id;
                    if (r_grant_id) begin
                        w_nxt_p1_rd = mem_rd_data;
                    end else begin
                        w_nxt_p0_rd = mem_rd_data;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 2'd1;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        w_nxt_busy = (w_nxt_state != S_IDLE);
    end

    assign p0_ack        = r_p0_ack;
    assign p1_ack        = r_p1_ack;
    assign p0_rd_data    = r_p0_rd;
    assign p1_rd_data    = r_p1_rd;
    assign mem_rd_enable = r_rd_en;
    assign mem_wr_enable = r_wr_en;
    assign mem_addr      = r_addr;
    assign mem_wr_data   = r_wdata;
    assign busy          = r_busy;
    assign grant_id      = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_mem_arbiter : bench for mem_arbiter at read latency 1 (dut 0) and 2 (1)  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [15:0] a;
        logic [7:0]  dt;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic        rst_n [2];
    logic        req   [2][2];
    logic        we    [2][2];
    logic [15:0] addr  [2][2];
    logic [7:0]  wd    [2][2];
    wire         ack   [2][2];
    wire  [7:0]  rd    [2][2];
    wire         mre   [2];
    wire         mwe   [2];
    wire  [15:0] ma    [2];
    wire  [7:0]  mwd   [2];
    wire  [7:0]  mrd   [2];
    wire         busy  [2];
    wire         gid   [2];

    for (genvar gd = 0; gd < 2; gd++) begin : g_dut
        bit   [7:0] bmem [65536];
        logic [7:0] stg1;
        logic [7:0] stg2;

        mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RD_LATENCY(gd + 1)) u_dut (
            .clk(clk), .reset(rst_n[gd]),
            .p0_req(req[gd][0]), .p0_we(we[gd][0]), .p0_addr(addr[gd][0]),
            .p0_wr_data(wd[gd][0]), .p0_ack(ack[gd][0]), .p0_rd_data(rd[gd][0]),
            .p1_req(req[gd][1]), .p1_we(we[gd][1]), .p1_addr(addr[gd][1]),
            .p1_wr_data(wd[gd][1]), .p1_ack(ack[gd][1]), .p1_rd_data(rd[gd][1]),
            .mem_rd_enable(mre[gd]), .mem_wr_enable(mwe[gd]), .mem_addr(ma[gd]),
            .mem_wr_data(mwd[gd]), .mem_rd_data(mrd[gd]),
            .busy(busy[gd]), .grant_id(gid[gd])
        );

        // BRAM stand-in: read data is only meaningful exactly RD_LATENCY cycles after the strobe
        always @(posedge clk) begin
            if (mwe[gd]) bmem[ma[gd]] <= mwd[gd];
            stg1 <= mre[gd] ? bmem[ma[gd]] : 8'($urandom);
            stg2 <= mre[gd] ? 8'($urandom) : stg1;
        end
        assign mrd[gd] = (gd == 0) ? stg1 : stg2;
    end

    // Transaction-level reference model
    op_t        q [4][$];
    int         cyc [2], g [2], ackc [2], free_at [2], win [2];
    op_t        cur [2];
    logic       m_gid [2];
    logic [15:0] m_ma [2];
    logic [7:0]  m_wd [2];
    logic [7:0]  ref_rd [2][2];
    logic [7:0]  exp_rd [2];
    bit   [7:0]  ref_mem [2][65536];
    int          mode = 0;   // 0 quiet, 1 move in-flight address to 0x0200, 2 randomise in-flight fields

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc[d], obs, expv);
        end
    endtask

    task automatic model_reset(input int d);
        g[d] = -100; ackc[d] = -100; free_at[d] = cyc[d];
        m_gid[d] = 1'b1; m_ma[d] = '0; m_wd[d] = '0;
        ref_rd[d][0] = '0; ref_rd[d][1] = '0;
        q[2*d].delete(); q[2*d+1].delete();
    endtask

    task automatic push(input int d, input int p, input logic w, input logic [15:0] a, input logic [7:0] dt);
        op_t o;
        o.we = w; o.a = a; o.dt = dt;
        q[2*d+p].push_back(o);
    endtask

    // Called once per cycle at the falling edge: check, drive requesters, predict next grant
    task automatic step(input int d);
        int  c;
        bit  fl;
        int  w;
        op_t h;
        c  = cyc[d];
        fl = (c > g[d]) && (c <= ackc[d]);
        if (fl && c == ackc[d] && !cur[d].we) ref_rd[d][win[d]] = exp_rd[d];
        chk("wr_enable", d, 32'(mwe[d]), 32'(fl && c == g[d] + 1 && cur[d].we));
        chk("rd_enable", d, 32'(mre[d]), 32'(fl && c == g[d] + 1 && !cur[d].we));
        chk("mem_addr", d, 32'(ma[d]), 32'(m_ma[d]));
        chk("mem_wr_data", d, 32'(mwd[d]), 32'(m_wd[d]));
        chk("busy", d, 32'(busy[d]), 32'(fl));
        chk("grant_id", d, 32'(gid[d]), 32'(m_gid[d]));
        for (int p = 0; p < 2; p++) begin
            chk(p == 0 ? "p0_ack" : "p1_ack", d, 32'(ack[d][p]), 32'(fl && c == ackc[d] && win[d] == p));
            chk(p == 0 ? "p0_rd_data" : "p1_rd_data", d, 32'(rd[d][p]), 32'(ref_rd[d][p]));
        end
        for (int p = 0; p < 2; p++) begin
            if (fl && c == ackc[d] && win[d] == p) void'(q[2*d+p].pop_front());
            if (q[2*d+p].size() > 0) begin
                h = q[2*d+p][0];
                req[d][p] = 1'b1; we[d][p] = h.we; addr[d][p] = h.a; wd[d][p] = h.dt;
            end else begin
                req[d][p] = 1'b0;
            end
        end
        if (fl && c > g[d] + 1 && c < ackc[d] && mode == 1) addr[d][win[d]] = 16'h0200;
        if (fl && c < ackc[d] && mode == 2) begin
            we[d][win[d]] = 1'($urandom); addr[d][win[d]] = 16'($urandom); wd[d][win[d]] = 8'($urandom);
        end
        if (c >= free_at[d] && (req[d][0] || req[d][1])) begin
            w = (req[d][0] && req[d][1]) ? (m_gid[d] ? 0 : 1) : (req[d][1] ? 1 : 0);
            cur[d].we = we[d][w]; cur[d].a = addr[d][w]; cur[d].dt = wd[d][w];
            win[d] = w; g[d] = c;
            ackc[d] = c + (cur[d].we ? 2 : 2 + (d + 1));
            free_at[d] = ackc[d] + 1;
            m_gid[d] = (w == 1); m_ma[d] = cur[d].a; m_wd[d] = cur[d].dt;
            if (cur[d].we) ref_mem[d][cur[d].a] = cur[d].dt;
            else exp_rd[d] = ref_mem[d][cur[d].a];
        end
        cyc[d]++;
    endtask

    task automatic run(input int d, input int budget);
        int n = 0;
        while ((q[2*d].size() > 0 || q[2*d+1].size() > 0 || cyc[d] <= ackc[d]) && n < budget) begin
            @(negedge clk); step(d); n++;
        end
        chk("completion_timeout", d, 32'(n < budget), 32'd1);
        repeat (2) begin @(negedge clk); step(d); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 0; model_reset(d);
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wd[d][p] = '0;
            end
        end
        repeat (3) @(negedge clk);
        step(0); step(1);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (3) begin @(negedge clk); step(0); step(1); end

        for (int d = 0; d < 2; d++) begin
            // single write, then read-back on the other port
            push(d, 0, 1'b1, 16'h1234, 8'hA5); run(d, 20);
            push(d, 1, 1'b0, 16'h1234, 8'h00); run(d, 20);

            // contention from the first cycle after reset
            @(negedge clk); rst_n[d] = 1'b0;
            @(negedge clk); rst_n[d] = 1'b1; model_reset(d);
            push(d, 0, 1'b1, 16'h0010, 8'h11); push(d, 0, 1'b1, 16'h0010, 8'h11);
            push(d, 1, 1'b1, 16'h0020, 8'h22); push(d, 1, 1'b1, 16'h0020, 8'h22);
            step(d); run(d, 40);

            // give p0 read data to lose, then reset in the WAIT cycle of the next p0 read
            push(d, 0, 1'b0, 16'h0010, 8'h00); run(d, 20);
            push(d, 0, 1'b0, 16'h0020, 8'h00);
            begin
                int gb = g[d];
                int n  = 0;
                while (!(g[d] != gb && cyc[d] == g[d] + 3) && n < 20) begin
                    @(negedge clk); step(d); n++;
                end
                chk("reach_wait_timeout", d, 32'(n < 20), 32'd1);
            end
            rst_n[d] = 1'b0;
            @(negedge clk); rst_n[d] = 1'b1; model_reset(d);
            step(d);
            repeat (4) begin @(negedge clk); step(d); end

            // in-flight address change must be ignored
            push(d, 1, 1'b1, 16'h0100, 8'h3C); push(d, 1, 1'b1, 16'h0200, 8'hC3);
            run(d, 30);
            mode = 1;
            push(d, 1, 1'b0, 16'h0100, 8'h00); run(d, 20);
            mode = 0;
        end

        mode = 2;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 25; i++) begin
                for (int p = 0; p < 2; p++) begin
                    push(d, p, 1'($urandom), 16'($urandom_range(0, 15)), 8'($urandom));
                end
            end
            run(d, 2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
